// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 definitions for the iterative round controller: constants,
// FSM state encoding, Rcon table, byte-lane helper and the round transforms
// (S-box, SubBytes, ShiftRows, MixColumns) as combinational functions.
// Byte k of any 128-bit word sits at [8k+7:8k]; FIPS-197 byte 0 is at [7:0],
// so column c of the AES state is made up of bytes 4c..4c+3, with row 0 first.
package aes_pkg;

  localparam int         NR         = 10;
  localparam int         BLOCK_W    = 128;
  localparam int         KEY_W      = 128;
  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] get_byte(input logic [127:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  // Round constants for rnd 1..10; every other index yields zero
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // S-box computed as the GF(2^8) inverse (a^254, which maps 0 to 0)
  // followed by the FIPS-197 affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox(get_byte(s, k));
    return r;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4)
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[8*(row + 4*col) +: 8] = get_byte(s, row + 4*((col + row) % 4));
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      a0 = get_byte(s, 4*col);
      a1 = get_byte(s, 4*col + 1);
      a2 = get_byte(s, 4*col + 2);
      a3 = get_byte(s, 4*col + 3);
      r[8*(4*col)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[8*(4*col + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[8*(4*col + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[8*(4*col + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_key_step.sv
// aes_key_step: combinational AES-128 key-schedule step. Produces the next
// round key from the current one and that round's Rcon byte. Words are 32-bit
// lanes with w0 at [31:0]; inside a word the FIPS first byte is at [7:0].
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon_byte,
  output logic [127:0] next_key
);

  logic [31:0] w3_rot;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  // RotWord, SubWord and Rcon applied to w3, then chained XOR through w0..w3
  always_comb begin
    w3_rot = {key[103:96], key[127:104]};
    temp   = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
              sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])} ^ {24'h000000, rcon_byte};
    n0       = key[31:0]   ^ temp;
    n1       = key[63:32]  ^ n0;
    n2       = key[95:64]  ^ n1;
    n3       = key[127:96] ^ n2;
    next_key = {n3, n2, n1, n0};
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer, one round per clock.
// Accepts a plaintext/key pair in IDLE, runs rounds 1..10 in ROUND (MixColumns
// skipped in round 10) and holds the ciphertext in DONE until taken.
// Optional debug visibility is enabled by defining AES_ROUND_DBG_EN, which adds
// oDbgState, oDbgRound and oDbgStrobe.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iValid,
  output logic         oReady,
  input  logic [127:0] iData,
  input  logic [127:0] iKey,
  output logic         oValid,
  input  logic         iReady,
  output logic [127:0] oData,
  output logic         oBusy
`ifdef AES_ROUND_DBG_EN
  ,
  output logic [127:0] oDbgState,
  output logic [3:0]   oDbgRound,
  output logic [0:0]   oDbgStrobe
`endif
);

  state_t       fsm;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [3:0]   rnd;
  logic [7:0]   rcon_cur;
  logic [127:0] rk;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] round_out;
  logic         rnd_bad;

  aes_key_step u_key_step (
    .key       (key_q),
    .rcon_byte (rcon_cur),
    .next_key  (rk)
  );

  // Round datapath; the last round skips MixColumns
  always_comb begin
    rcon_cur  = rcon(rnd);
    sr_out    = shift_rows(sub_bytes(state_q));
    mc_out    = mix_columns(sr_out);
    round_out = ((rnd == LAST_ROUND) ? sr_out : mc_out) ^ rk;
    rnd_bad   = (rnd == 4'd0) || (rnd > LAST_ROUND);
  end

  // Controller FSM with registered handshake outputs and ciphertext capture
  always_ff @(posedge iClk) begin
    if (iRst) begin
      fsm     <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd     <= 4'd0;
      oReady  <= 1'b1;
      oValid  <= 1'b0;
      oBusy   <= 1'b0;
      oData   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (iValid) begin
            state_q <= iData ^ iKey;
            key_q   <= iKey;
            rnd     <= 4'd1;
            fsm     <= ROUND;
            oReady  <= 1'b0;
            oBusy   <= 1'b1;
          end
        end
        ROUND: begin
          if (rnd_bad) begin
            fsm    <= IDLE;
            rnd    <= 4'd0;
            oReady <= 1'b1;
            oBusy  <= 1'b0;
          end else begin
            key_q <= rk;
            if (rnd == LAST_ROUND) begin
              oData  <= round_out;
              oValid <= 1'b1;
              oBusy  <= 1'b0;
              rnd    <= 4'd0;
              fsm    <= DONE;
            end else begin
              state_q <= round_out;
              rnd     <= rnd + 4'd1;
            end
          end
        end
        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            oReady <= 1'b1;
            fsm    <= IDLE;
          end
        end
        default: begin
          fsm    <= IDLE;
          rnd    <= 4'd0;
          oReady <= 1'b1;
          oValid <= 1'b0;
          oBusy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_ROUND_DBG_EN
  logic dbg_strobe;

  // One-cycle pulse following every executed round edge
  always_ff @(posedge iClk) begin
    if (iRst) dbg_strobe <= 1'b0;
    else      dbg_strobe <= (fsm == ROUND) && !rnd_bad;
  end

  assign oDbgState  = state_q;
  assign oDbgRound  = rnd;
  assign oDbgStrobe = dbg_strobe;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: FIPS-197 vectors, backpressure, back-to-back
// throughput and mid-run reset, with a queue of expected ciphertexts.
module tb_aes_round_ctrl;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iValid;
  logic         oReady;
  logic [127:0] iData;
  logic [127:0] iKey;
  logic         oValid;
  logic         iReady;
  logic [127:0] oData;
  logic         oBusy;
`ifdef AES_ROUND_DBG_EN
  logic [127:0] oDbgState;
  logic [3:0]   oDbgRound;
  logic [0:0]   oDbgStrobe;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_R2  = 128'ha49c7ff2689f352b6b5bea43026a5049;

  aes_round_ctrl dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iData  (iData),
    .iKey   (iKey),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (oData),
    .oBusy  (oBusy)
`ifdef AES_ROUND_DBG_EN
    ,
    .oDbgState  (oDbgState),
    .oDbgRound  (oDbgRound),
    .oDbgStrobe (oDbgStrobe)
`endif
  );

  always #5 iClk = ~iClk;

  // Convert a FIPS hex string (byte 0 leftmost) to the bus layout (byte 0 at [7:0])
  function automatic logic [127:0] fips(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s[127 - 8*k -: 8];
    return r;
  endfunction

  // Offer one block in IDLE; the accept edge is the posedge inside this task
  task automatic accept_block(input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] ct);
    @(negedge iClk);
    iValid = 1'b1;
    iData  = fips(pt);
    iKey   = fips(key);
    @(posedge iClk);
    exp_q.push_back(fips(ct));
    #1 iValid = 1'b0;
  endtask

  // Negedges after the accept edge until oValid; n = 40 means it never came
  task automatic wait_valid(output int n);
    for (n = 0; n < 40; n++) begin
      @(negedge iClk);
      if (oValid) break;
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_oReady got %b want 1", oReady); end
    checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_oValid got %b want 0", oValid); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_oBusy got %b want 0", oBusy); end
    checks++; if (oData !== 128'h0) begin errors++; $display("[TB] FAIL reset_oData got %h want 0", oData); end
    iRst = 1'b0;
  endtask

  task automatic test_app_b();
    int n;
    logic [127:0] e;
    iReady = 1'b1;
    accept_block(B_PT, B_KEY, B_CT);
    for (n = 0; n < 40; n++) begin
      @(negedge iClk);
      if (n == 0) begin
        checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL appb_busy got %b want 1", oBusy); end
        checks++; if (oReady !== 1'b0) begin errors++; $display("[TB] FAIL appb_ready got %b want 0", oReady); end
      end
      if (oValid) break;
    end
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL appb_latency got %0d want 10", n); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (oData !== e) begin errors++; $display("[TB] FAIL appb_data got %h want %h", oData, e); end
    @(negedge iClk);
    checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL appb_handshake_valid got %b want 0", oValid); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL appb_handshake_ready got %b want 1", oReady); end
  endtask

  task automatic test_app_c();
    int n;
    logic [127:0] e;
    iReady = 1'b1;
    accept_block(C_PT, C_KEY, C_CT);
    wait_valid(n);
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL appc_latency got %0d want 10", n); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (oData !== e) begin errors++; $display("[TB] FAIL appc_data got %h want %h", oData, e); end
    @(negedge iClk);
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] e;
    iReady = 1'b0;
    accept_block(B_PT, B_KEY, B_CT);
    wait_valid(n);
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL bp_latency got %0d want 10", n); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        iValid = 1'b1;
        iData  = fips(C_PT);
        iKey   = fips(C_KEY);
      end else begin
        iValid = 1'b0;
      end
      @(negedge iClk);
      checks++; if (oValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid cycle %0d got %b want 1", i, oValid); end
      checks++; if (oData !== e) begin errors++; $display("[TB] FAIL bp_hold_data cycle %0d got %h want %h", i, oData, e); end
      checks++; if (oReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_ready cycle %0d got %b want 0", i, oReady); end
    end
    iValid = 1'b0;
    iReady = 1'b1;
    @(negedge iClk);
    checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid got %b want 0", oValid); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b want 1", oReady); end
    @(negedge iClk);
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL bp_second_not_accepted busy got %b want 0", oBusy); end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int popped;
    int acc_cycle[2];
    logic last_ready;
    logic [127:0] e;
    accepts = 0;
    popped  = 0;
    acc_cycle[0] = 0;
    acc_cycle[1] = 0;
    @(negedge iClk);
    iValid = 1'b1;
    iReady = 1'b1;
    iData  = fips(B_PT);
    iKey   = fips(B_KEY);
    last_ready = oReady;
    for (int c = 0; c < 60 && popped < 2; c++) begin
      @(negedge iClk);
      if (last_ready && iValid) begin
        if (accepts == 0) begin
          exp_q.push_back(fips(B_CT));
          iData = fips(C_PT);
          iKey  = fips(C_KEY);
        end else begin
          exp_q.push_back(fips(C_CT));
          iValid = 1'b0;
        end
        if (accepts < 2) acc_cycle[accepts] = c;
        accepts++;
      end
      if (oValid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        checks++; if (oData !== e) begin errors++; $display("[TB] FAIL b2b_data block %0d got %h want %h", popped, oData, e); end
        popped++;
      end
      last_ready = oReady;
    end
    iValid = 1'b0;
    checks++; if (popped != 2) begin errors++; $display("[TB] FAIL b2b_outputs got %0d want 2", popped); end
    checks++; if (acc_cycle[1] - acc_cycle[0] != 12) begin errors++; $display("[TB] FAIL b2b_period got %0d want 12", acc_cycle[1] - acc_cycle[0]); end
    @(negedge iClk);
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic [127:0] e;
    iReady = 1'b1;
    accept_block(B_PT, B_KEY, B_CT);
    repeat (5) @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk);
    #1 iRst = 1'b0;
    void'(exp_q.pop_front());
    @(negedge iClk);
    checks++; if (oValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", oValid); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", oBusy); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b want 1", oReady); end
    checks++; if (oData !== 128'h0) begin errors++; $display("[TB] FAIL midrst_data got %h want 0", oData); end
    accept_block(B_PT, B_KEY, B_CT);
    wait_valid(n);
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL midrst_rerun_latency got %0d want 10", n); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (oData !== e) begin errors++; $display("[TB] FAIL midrst_rerun_data got %h want %h", oData, e); end
    @(negedge iClk);
  endtask

`ifdef AES_ROUND_DBG_EN
  task automatic test_debug();
    int n;
    logic [127:0] e;
    iReady = 1'b1;
    accept_block(B_PT, B_KEY, B_CT);
    for (n = 0; n < 40; n++) begin
      @(negedge iClk);
      if (oValid) break;
      checks++; if (oDbgRound !== 4'(n + 1)) begin errors++; $display("[TB] FAIL dbg_round edge %0d got %0d want %0d", n, oDbgRound, n + 1); end
      if (n == 1) begin
        checks++; if (oDbgStrobe !== 1'b1) begin errors++; $display("[TB] FAIL dbg_strobe got %b want 1", oDbgStrobe); end
        checks++; if (oDbgState !== fips(B_R2)) begin errors++; $display("[TB] FAIL dbg_state_r1 got %h want %h", oDbgState, fips(B_R2)); end
      end
    end
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL dbg_latency got %0d want 10", n); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (oData !== e) begin errors++; $display("[TB] FAIL dbg_data got %h want %h", oData, e); end
    @(negedge iClk);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    iRst   = 1'b1;
    iValid = 1'b0;
    iReady = 1'b1;
    iData  = '0;
    iKey   = '0;
    test_reset();
    test_app_b();
    test_app_c();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef AES_ROUND_DBG_EN
    test_debug();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
